// File: rtl/mips_multicycle_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : mips_multicycle_ctrl_if
//  Description : Bundle between the multicycle MIPS datapath and its control
//                FSM. Carries the decoded-instruction fields and memory
//                handshake toward the controller, and every datapath select,
//                write enable, status flag and perf counter back out.
//                  master : datapath side (drives opcode/funct/alu_zero/
//                           mem_ready, observes controls)
//                  slave  : controller side
//  Revision    : 1.0  initial release
// ============================================================================
interface mips_multicycle_ctrl_if;
    // datapath -> controller
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        alu_zero;
    logic        mem_ready;
    // controller -> datapath
    logic        pc_write;
    logic        ir_write;
    logic        iord;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        reg_dst;
    logic        mem_to_reg;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic [1:0]  alu_op;
    logic [1:0]  pc_src;
    logic [3:0]  state;
    logic        instr_done;
    logic        illegal_op;
    logic        fault;
    logic [31:0] cycle_cnt;
    logic [31:0] instr_cnt;

    modport master (
        output opcode, funct, alu_zero, mem_ready,
        input  pc_write, ir_write, iord, mem_read, mem_write, reg_write,
               reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src,
               state, instr_done, illegal_op, fault, cycle_cnt, instr_cnt
    );

    modport slave (
        input  opcode, funct, alu_zero, mem_ready,
        output pc_write, ir_write, iord, mem_read, mem_write, reg_write,
               reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src,
               state, instr_done, illegal_op, fault, cycle_cnt, instr_cnt
    );
endinterface
`default_nettype wire

// File: rtl/mips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mips_multicycle_ctrl
//  Description : Multicycle control FSM for a shared MIPS datapath with a
//                single unified memory port. Sequences fetch/decode/execute,
//                waits on mem_ready, flags illegal opcodes and latches a
//                sticky fault when a memory access exceeds WAIT_LIMIT cycles.
//  Ports       : clk, reset (synchronous, active high)
//                bus (slave modport of mips_multicycle_ctrl_if)
//  Parameters  : WAIT_LIMIT - wait cycles tolerated before FAULT (0 = never)
//  Options     : MC_PERF_CNT_EN - when defined, cycle_cnt/instr_cnt are live
//                counters; otherwise both read constant zero.
//  Revision    : 1.0  initial release
// ============================================================================
module mips_multicycle_ctrl #(
    parameter int WAIT_LIMIT = 15
) (
    input  wire logic             clk,
    input  wire logic             reset,
    mips_multicycle_ctrl_if.slave bus
);

    localparam logic [3:0] c_FETCH  = 4'd0;
    localparam logic [3:0] c_DECODE = 4'd1;
    localparam logic [3:0] c_MEMADR = 4'd2;
    localparam logic [3:0] c_MEMRD  = 4'd3;
    localparam logic [3:0] c_MEMWB  = 4'd4;
    localparam logic [3:0] c_MEMWR  = 4'd5;
    localparam logic [3:0] c_EXEC   = 4'd6;
    localparam logic [3:0] c_ALUWB  = 4'd7;
    localparam logic [3:0] c_BRANCH = 4'd8;
    localparam logic [3:0] c_JUMP   = 4'd9;
    localparam logic [3:0] c_JR     = 4'd10;
    localparam logic [3:0] c_FAULT  = 4'd11;

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_J     = 6'b000010;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_FN_JR    = 6'b001000;

    localparam int               c_WCW      = (WAIT_LIMIT < 1) ? 1 : $clog2(WAIT_LIMIT + 1);
    localparam logic [c_WCW-1:0] c_WAIT_MAX = c_WCW'(WAIT_LIMIT);

    logic [3:0]       r_state;
    logic [3:0]       w_next;
    logic [c_WCW-1:0] r_wait_cnt;
    logic             r_fault;
    logic             w_is_wait;
    logic             w_timeout;
    logic             w_illegal;

    // raw (pre-reset-gating) control decode
    logic       w_pc_write, w_ir_write, w_iord, w_mem_read, w_mem_write;
    logic       w_reg_write, w_reg_dst, w_mem_to_reg, w_alu_src_a, w_instr_done;
    logic [1:0] w_alu_src_b, w_alu_op, w_pc_src;

    assign w_is_wait = (r_state == c_FETCH) || (r_state == c_MEMRD) || (r_state == c_MEMWR);
    // A mem_ready arriving on the limit cycle still completes normally.
    assign w_timeout = (WAIT_LIMIT > 0) && w_is_wait && !bus.mem_ready && (r_wait_cnt == c_WAIT_MAX);

    always_comb begin
        w_next    = r_state;
        w_illegal = 1'b0;
        case (r_state)
            c_FETCH:  if (bus.mem_ready) w_next = c_DECODE;
            c_DECODE: begin
                case (bus.opcode)
                    c_OP_LW, c_OP_SW: w_next = c_MEMADR;
                    c_OP_BEQ:         w_next = c_BRANCH;
                    c_OP_J:           w_next = c_JUMP;
                    c_OP_RTYPE:       w_next = (bus.funct == c_FN_JR) ? c_JR : c_EXEC;
                    default: begin
                        w_illegal = 1'b1;
                        w_next    = c_FETCH;
                    end
                endcase
            end
            c_MEMADR: w_next = (bus.opcode == c_OP_LW) ? c_MEMRD : c_MEMWR;
            c_MEMRD:  if (bus.mem_ready) w_next = c_MEMWB;
            c_MEMWR:  if (bus.mem_ready) w_next = c_FETCH;
            c_EXEC:   w_next = c_ALUWB;
            c_MEMWB, c_ALUWB, c_BRANCH, c_JUMP, c_JR: w_next = c_FETCH;
            c_FAULT:  w_next = c_FAULT;
            default:  w_next = c_FETCH;
        endcase
        if (w_timeout) w_next = c_FAULT;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_FETCH;
            r_fault    <= 1'b0;
            r_wait_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (w_timeout) r_fault <= 1'b1;
            // Any state change restarts the wait window for the new state.
            if (w_next != r_state)
                r_wait_cnt <= '0;
            else if (w_is_wait && !bus.mem_ready && (r_wait_cnt != '1))
                r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    always_comb begin
        w_pc_write   = 1'b0;
        w_ir_write   = 1'b0;
        w_iord       = 1'b0;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_reg_write  = 1'b0;
        w_reg_dst    = 1'b0;
        w_mem_to_reg = 1'b0;
        w_alu_src_a  = 1'b0;
        w_alu_src_b  = 2'b00;
        w_alu_op     = 2'b00;
        w_pc_src     = 2'b00;
        w_instr_done = 1'b0;
        case (r_state)
            c_FETCH: begin
                w_mem_read  = 1'b1;
                w_alu_src_b = 2'b01;
                w_ir_write  = bus.mem_ready;
                w_pc_write  = bus.mem_ready;
            end
            c_DECODE: w_alu_src_b = 2'b11;
            c_MEMADR: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
            end
            c_MEMRD: begin
                w_mem_read = 1'b1;
                w_iord     = 1'b1;
            end
            c_MEMWB: begin
                w_reg_write  = 1'b1;
                w_mem_to_reg = 1'b1;
                w_instr_done = 1'b1;
            end
            c_MEMWR: begin
                w_mem_write  = 1'b1;
                w_iord       = 1'b1;
                w_instr_done = bus.mem_ready;
            end
            c_EXEC: begin
                w_alu_src_a = 1'b1;
                w_alu_op    = 2'b10;
            end
            c_ALUWB: begin
                w_reg_write  = 1'b1;
                w_reg_dst    = 1'b1;
                w_instr_done = 1'b1;
            end
            c_BRANCH: begin
                w_alu_src_a  = 1'b1;
                w_alu_op     = 2'b01;
                w_pc_src     = 2'b01;
                w_pc_write   = bus.alu_zero;
                w_instr_done = 1'b1;
            end
            c_JUMP: begin
                w_pc_src     = 2'b10;
                w_pc_write   = 1'b1;
                w_instr_done = 1'b1;
            end
            c_JR: begin
                w_pc_src     = 2'b11;
                w_pc_write   = 1'b1;
                w_instr_done = 1'b1;
            end
            default: ;
        endcase
    end

    // Side-effecting strobes are suppressed during the reset cycle so an
    // abandoned instruction can never commit anything.
    assign bus.pc_write   = w_pc_write   & ~reset;
    assign bus.ir_write   = w_ir_write   & ~reset;
    assign bus.reg_write  = w_reg_write  & ~reset;
    assign bus.mem_write  = w_mem_write  & ~reset;
    assign bus.instr_done = w_instr_done & ~reset;
    assign bus.illegal_op = w_illegal    & ~reset;
    assign bus.iord       = w_iord;
    assign bus.mem_read   = w_mem_read;
    assign bus.reg_dst    = w_reg_dst;
    assign bus.mem_to_reg = w_mem_to_reg;
    assign bus.alu_src_a  = w_alu_src_a;
    assign bus.alu_src_b  = w_alu_src_b;
    assign bus.alu_op     = w_alu_op;
    assign bus.pc_src     = w_pc_src;
    assign bus.state      = r_state;
    assign bus.fault      = r_fault;

`ifdef MC_PERF_CNT_EN
    logic [31:0] r_cycle_cnt;
    logic [31:0] r_instr_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cycle_cnt <= '0;
            r_instr_cnt <= '0;
        end else if (r_state != c_FAULT) begin
            r_cycle_cnt <= r_cycle_cnt + 32'd1;
            if (w_instr_done) r_instr_cnt <= r_instr_cnt + 32'd1;
        end
    end

    assign bus.cycle_cnt = r_cycle_cnt;
    assign bus.instr_cnt = r_instr_cnt;
`else
    assign bus.cycle_cnt = 32'd0;
    assign bus.instr_cnt = 32'd0;
`endif

endmodule
`default_nettype wire
